// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and constants for the FIFO read-side stream framer.
package fifo_rd_stream_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int SKID_DEPTH = 2;
    localparam int SKID_CNTW  = $clog2(SKID_DEPTH + 1);

    localparam logic [SKID_CNTW-1:0] SKID_ONE  = SKID_CNTW'(1);
    localparam logic [SKID_CNTW-1:0] SKID_FULL = SKID_CNTW'(SKID_DEPTH);

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready register buffer; entry 0 is always the head presented downstream.
module stream_skid_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int W = 9
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic                 push_i,
    input  logic [W-1:0]         push_data_i,
    output logic                 valid_o,
    output logic [W-1:0]         data_o,
    input  logic                 ready_i,
    output logic [SKID_CNTW-1:0] count_o
);

    logic [SKID_CNTW-1:0] r_cnt;
    logic [W-1:0]         r_ent0;
    logic [W-1:0]         r_ent1;
    logic                 w_pop;

    assign w_pop = (r_cnt != '0) && ready_i;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_cnt <= '0;
        end else if (push_i && !w_pop) begin
            r_cnt <= r_cnt + SKID_ONE;
        end else if (w_pop && !push_i) begin
            r_cnt <= r_cnt - SKID_ONE;
        end
    end

    // Entries need no reset: r_cnt alone says which ones hold live data.
    always_ff @(posedge clk_i) begin
        case ({push_i, w_pop})
            2'b10: begin
                if (r_cnt == '0) begin
                    r_ent0 <= push_data_i;
                end else begin
                    r_ent1 <= push_data_i;
                end
            end
            2'b01: begin
                r_ent0 <= r_ent1;
            end
            2'b11: begin
                if (r_cnt == SKID_ONE) begin
                    r_ent0 <= push_data_i;
                end else begin
                    r_ent0 <= r_ent1;
                    r_ent1 <= push_data_i;
                end
            end
            default: begin
            end
        endcase
    end

    assign valid_o = (r_cnt != '0);
    assign data_o  = valid_o ? r_ent0 : '0;
    assign count_o = r_cnt;

endmodule

// File: rtl/fifo_rd_stream.sv
// Pops a show-ahead FIFO, keeps 1 of every decim words, and frames kept words into TLAST packets.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4,
    parameter int LENW   = 8
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              enable_i,
    input  logic [LENW-1:0]   pkt_len_i,
    input  logic [AWIDTH-1:0] decim_i,
    input  logic              fifo_empty_i,
    input  logic [DWIDTH-1:0] fifo_rddata_i,
    output logic              fifo_rd_o,
    output logic [AWIDTH-1:0] fifo_shift_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    output logic              last_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              pkt_done_o
);

    localparam logic [LENW:0]     BEAT_ONE  = (LENW+1)'(1);
    localparam logic [AWIDTH-1:0] PHASE_ONE = AWIDTH'(1);

    logic [1:0]           r_rst_sync;
    logic                 w_rst_n;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [LENW:0]        r_len;
    logic [LENW:0]        w_len_nxt;
    logic [AWIDTH-1:0]    r_decim;
    logic [AWIDTH-1:0]    w_decim_nxt;
    logic [LENW:0]        r_beat;
    logic [LENW:0]        w_beat_nxt;
    logic [AWIDTH-1:0]    r_phase;
    logic [AWIDTH-1:0]    w_phase_nxt;

    logic [LENW:0]        w_len_in;
    logic [AWIDTH-1:0]    w_decim_in;
    logic                 w_pop;
    logic                 w_keep;
    logic                 w_last;
    logic                 w_phase_wrap;
    logic [SKID_CNTW-1:0] w_skid_cnt;
    logic                 w_skid_valid;
    logic [DWIDTH:0]      w_skid_data;

    // Assert immediately, release two clocks after arst_n_i rises.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_len_in   = (pkt_len_i == '0) ? {1'b1, {LENW{1'b0}}} : {1'b0, pkt_len_i};
    assign w_decim_in = (decim_i == '0) ? PHASE_ONE : decim_i;

    always_comb begin
        w_state_nxt  = r_state;
        w_len_nxt    = r_len;
        w_decim_nxt  = r_decim;
        w_beat_nxt   = r_beat;
        w_phase_nxt  = r_phase;
        w_pop        = 1'b0;
        w_keep       = 1'b0;
        w_last       = 1'b0;
        w_phase_wrap = (r_phase == (r_decim - PHASE_ONE));

        case (r_state)
            IDLE: begin
                if (enable_i) begin
                    w_state_nxt = RUN;
                    w_len_nxt   = w_len_in;
                    w_decim_nxt = w_decim_in;
                    w_beat_nxt  = '0;
                    w_phase_nxt = '0;
                end
            end
            RUN: begin
                // Only the registered skid count gates the pop, keeping ready_i off fifo_rd_o.
                w_pop = !fifo_empty_i && (w_skid_cnt < SKID_FULL);
                if (w_pop) begin
                    w_keep      = (r_phase == '0);
                    w_last      = w_keep && (r_beat == (r_len - BEAT_ONE));
                    w_phase_nxt = w_phase_wrap ? '0 : (r_phase + PHASE_ONE);
                    if (w_keep) begin
                        w_beat_nxt = r_beat + BEAT_ONE;
                    end
                    // Packet closes once its final decimation group has been fully consumed.
                    if (w_phase_wrap && (w_beat_nxt == r_len)) begin
                        if (enable_i) begin
                            w_len_nxt   = w_len_in;
                            w_decim_nxt = w_decim_in;
                            w_beat_nxt  = '0;
                            w_phase_nxt = '0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_decim <= '0;
            r_beat  <= '0;
            r_phase <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
            r_decim <= w_decim_nxt;
            r_beat  <= w_beat_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    stream_skid_buf #(
        .W(DWIDTH + 1)
    ) u_skid (
        .clk_i       (clk_i),
        .arst_n_i    (w_rst_n),
        .push_i      (w_keep),
        .push_data_i ({w_last, fifo_rddata_i}),
        .valid_o     (w_skid_valid),
        .data_o      (w_skid_data),
        .ready_i     (ready_i),
        .count_o     (w_skid_cnt)
    );

    assign fifo_rd_o    = w_pop;
    assign fifo_shift_o = PHASE_ONE;
    assign valid_o      = w_skid_valid;
    assign data_o       = w_skid_data[DWIDTH-1:0];
    assign last_o       = w_skid_data[DWIDTH];
    assign busy_o       = (r_state != IDLE) || (w_skid_cnt != '0);
    assign pkt_done_o   = w_skid_valid && ready_i && w_skid_data[DWIDTH];

endmodule
